// File: rtl/freq_meas_ctrl_if.sv
// freq_meas_ctrl_if: result handshake between the measurement sequencer and the readout logic
interface freq_meas_ctrl_if #(parameter int COUNT_W = 14);
    logic               result_valid;
    logic               result_ready;
    logic [COUNT_W-1:0] count_out;
    logic [1:0]         range_out;
    logic               overflow;
    modport master (output result_valid, count_out, range_out, overflow, input result_ready);
    modport slave  (input result_valid, count_out, range_out, overflow, output result_ready);
endinterface

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: gated edge counter with 1 s / 100 ms / 10 ms ranges, autoranging and valid/ready result
module freq_meas_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int COUNT_W    = 14,
    parameter int LOW_THRESH = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             signal_in,
    input  logic             start,
    input  logic             continuous,
    input  logic             autorange_en,
    input  logic [1:0]       range_sel,
    output logic             busy,
    freq_meas_ctrl_if.master res
);
    localparam int GW = $clog2(CLK_HZ + 1);
    localparam logic [COUNT_W-1:0] MAX = '1;

    typedef enum logic [2:0] {IDLE, ARM, GATE, EVAL, PRESENT} state_t;

    state_t             r_state, w_next;
    logic               r_s1, r_s2, r_s3, r_ovf, r_auto;
    logic [GW-1:0]      r_gcnt, w_glast;
    logic [COUNT_W-1:0] r_cnt;
    logic [1:0]         r_range;
    logic               w_edge, w_up, w_dn, w_xfer;

    assign w_edge  = r_s2 & ~r_s3;
    assign w_glast = r_range == 2'd0 ? GW'(CLK_HZ - 1) :
                     r_range == 2'd1 ? GW'(CLK_HZ / 10 - 1) : GW'(CLK_HZ / 100 - 1);
    // A re-measure is only allowed in the direction that can still move
    assign w_up    = r_auto & r_ovf & (r_range < 2'd2);
    assign w_dn    = r_auto & ~w_up & (r_cnt < COUNT_W'(LOW_THRESH)) & (r_range != 2'd0);
    assign w_xfer  = res.result_valid & res.result_ready;
    assign busy    = r_state != IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? ARM : IDLE;
            ARM:     w_next = GATE;
            GATE:    w_next = r_gcnt == w_glast ? EVAL : GATE;
            EVAL:    w_next = (w_up | w_dn) ? ARM : PRESENT;
            PRESENT: w_next = w_xfer ? (continuous ? ARM : IDLE) : PRESENT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            {r_s1, r_s2, r_s3} <= 3'b000;
        end else begin
            r_state <= w_next;
            {r_s1, r_s2, r_s3} <= {signal_in, r_s1, r_s2};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gcnt           <= '0;
            r_cnt            <= '0;
            r_ovf            <= 1'b0;
            r_auto           <= 1'b0;
            r_range          <= 2'd0;
            res.result_valid <= 1'b0;
            res.count_out    <= '0;
            res.range_out    <= 2'd0;
            res.overflow     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_auto <= autorange_en;
                    if (!autorange_en) r_range <= range_sel == 2'd3 ? 2'd2 : range_sel;
                end
                ARM: begin
                    r_gcnt <= '0;
                    r_cnt  <= '0;
                    r_ovf  <= 1'b0;
                end
                GATE: begin
                    r_gcnt <= r_gcnt + 1'b1;
                    if (w_edge && r_cnt == MAX) r_ovf <= 1'b1;
                    else if (w_edge)            r_cnt <= r_cnt + 1'b1;
                end
                EVAL: begin
                    if (w_up)      r_range <= r_range + 2'd1;
                    else if (w_dn) r_range <= r_range - 2'd1;
                    else begin
                        res.result_valid <= 1'b1;
                        res.count_out    <= r_cnt;
                        res.range_out    <= r_range;
                        res.overflow     <= r_ovf;
                    end
                end
                PRESENT: if (w_xfer) res.result_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
